psg_env_ctrl: RTL and testbench

Volume-envelope sequencer and attribute-write arbiter in front of the PSG. It owns the PSG attribute write port and merges two sources onto it: CPU attribute writes, which pass through, and envelope writes generated by the block. Once per envelope tick it walks all channels and ramps each channel's volume toward a per-channel target at a programmable rate. It sits between the CPU register decode and the PSG.

---
 rtl/psg_env_ctrl.sv | 143 ++++++++++++++
 tb/tb_psg_env_ctrl.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/psg_env_ctrl.sv
// Volume-envelope sequencer and attribute-write arbiter in front of the PSG.
// CPU attribute writes pass through; once per tick each channel's volume is ramped toward its target.
module psg_env_ctrl #(
  parameter int NUM_CH   = 16,
  parameter int TICK_DIV = 256
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] cpu_addr,
  input  logic [7:0] cpu_wrdata,
  input  logic       cpu_write,
  input  logic [3:0] env_addr,
  input  logic [7:0] env_wrdata,
  input  logic       env_write,
  input  logic       next_sample,
  output logic [5:0] psg_attr_addr,
  output logic [7:0] psg_attr_wrdata,
  output logic       psg_attr_write,
  output logic       busy,
  output logic       tick_overrun
);

  localparam int              CW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0]   TICK_LAST = CW'(TICK_DIV - 1);
  localparam logic [3:0]      LAST_CH   = 4'(NUM_CH - 1);

  typedef enum logic [1:0] {IDLE, SCAN, WRITE} state_t;

  state_t        state;
  logic [3:0]    ch_r;
  logic [5:0]    nv_r;
  logic [CW-1:0] tick_cnt;
  logic [5:0]    vol_r [NUM_CH];
  logic [1:0]    lr_r  [NUM_CH];
  logic [7:0]    cfg_r [NUM_CH];

  logic       tick;
  logic       snoop;
  logic       last_ch;
  logic [6:0] vol7, tgt7, step7, up7, dn7;
  logic [5:0] nv;

  // Ramp is computed 7 bits wide so neither direction can wrap past 0 or 63.
  always_comb begin
    tick    = next_sample && (tick_cnt == TICK_LAST);
    snoop   = cpu_write && (cpu_addr[1:0] == 2'd2);
    last_ch = (ch_r == LAST_CH);
    vol7    = {1'b0, vol_r[ch_r]};
    tgt7    = {1'b0, cfg_r[ch_r][5:0]};
    step7   = 7'd1 << cfg_r[ch_r][7:6];
    up7     = vol7 + step7;
    dn7     = vol7 - step7;
    nv      = vol_r[ch_r];
    if (vol7 < tgt7)
      nv = (up7 > tgt7) ? tgt7[5:0] : up7[5:0];
    else if (vol7 > tgt7)
      nv = (vol7 < tgt7 + step7) ? tgt7[5:0] : dn7[5:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      ch_r            <= '0;
      nv_r            <= '0;
      tick_cnt        <= '0;
      busy            <= 1'b0;
      tick_overrun    <= 1'b0;
      psg_attr_addr   <= '0;
      psg_attr_wrdata <= '0;
      psg_attr_write  <= 1'b0;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        vol_r[i] <= '0;
        lr_r[i]  <= '0;
        cfg_r[i] <= '0;
      end
    end else begin
      psg_attr_write <= 1'b0;
      tick_overrun   <= tick && (state != IDLE);

      if (next_sample)
        tick_cnt <= (tick_cnt == TICK_LAST) ? '0 : tick_cnt + CW'(1);

      if (env_write)
        cfg_r[env_addr] <= env_wrdata;

      if (cpu_write) begin
        psg_attr_addr   <= cpu_addr;
        psg_attr_wrdata <= cpu_wrdata;
        psg_attr_write  <= 1'b1;
      end

      if (snoop) begin
        vol_r[cpu_addr[5:2]] <= cpu_wrdata[5:0];
        lr_r[cpu_addr[5:2]]  <= cpu_wrdata[7:6];
      end

      case (state)
        IDLE: begin
          if (tick) begin
            state <= SCAN;
            ch_r  <= '0;
            busy  <= 1'b1;
          end
        end
        SCAN: begin
          if (nv != vol_r[ch_r]) begin
            nv_r  <= nv;
            state <= WRITE;
          end else if (last_ch) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            ch_r <= ch_r + 4'd1;
          end
        end
        WRITE: begin
          // A CPU write owns the port this cycle; rescan the same channel so
          // the new volume is derived from the possibly snooped shadow.
          if (cpu_write) begin
            state <= SCAN;
          end else begin
            psg_attr_addr   <= {ch_r, 2'b10};
            psg_attr_wrdata <= {lr_r[ch_r], nv_r};
            psg_attr_write  <= 1'b1;
            vol_r[ch_r]     <= nv_r;
            if (last_ch) begin
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              state <= SCAN;
              ch_r  <= ch_r + 4'd1;
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_psg_env_ctrl.sv
// Directed bench for psg_env_ctrl: passthrough, ramps, clamping, collisions, overrun, reset and tick division.
module tb_psg_env_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] cpu_addr = '0;
  logic [7:0] cpu_wrdata = '0;
  logic       cpu_write = 1'b0;
  logic [3:0] env_addr = '0;
  logic [7:0] env_wrdata = '0;
  logic       env_write = 1'b0;
  logic       next_sample = 1'b0;
  logic [5:0] psg_attr_addr;
  logic [7:0] psg_attr_wrdata;
  logic       psg_attr_write;
  logic       busy;
  logic       tick_overrun;

  logic       ns3 = 1'b0;
  logic [5:0] d_addr;
  logic [7:0] d_data;
  logic       d_write, d_busy, d_ovr;

  int n_checks = 0;
  int n_fail   = 0;
  logic [13:0] wlog [$];

  always #5 clk = ~clk;

  psg_env_ctrl #(.NUM_CH(16), .TICK_DIV(1)) u_dut (
    .clk(clk), .rst(rst),
    .cpu_addr(cpu_addr), .cpu_wrdata(cpu_wrdata), .cpu_write(cpu_write),
    .env_addr(env_addr), .env_wrdata(env_wrdata), .env_write(env_write),
    .next_sample(next_sample),
    .psg_attr_addr(psg_attr_addr), .psg_attr_wrdata(psg_attr_wrdata),
    .psg_attr_write(psg_attr_write), .busy(busy), .tick_overrun(tick_overrun)
  );

  psg_env_ctrl #(.NUM_CH(16), .TICK_DIV(3)) u_div (
    .clk(clk), .rst(rst),
    .cpu_addr(6'd0), .cpu_wrdata(8'd0), .cpu_write(1'b0),
    .env_addr(4'd0), .env_wrdata(8'd0), .env_write(1'b0),
    .next_sample(ns3),
    .psg_attr_addr(d_addr), .psg_attr_wrdata(d_data),
    .psg_attr_write(d_write), .busy(d_busy), .tick_overrun(d_ovr)
  );

  always @(negedge clk)
    if (psg_attr_write) wlog.push_back({psg_attr_addr, psg_attr_wrdata});

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; cpu_write = 1'b0; env_write = 1'b0; next_sample = 1'b0; ns3 = 1'b0;
    step(); step();
    rst = 1'b0;
    step();
    wlog.delete();
  endtask

  task automatic cpu_wr(input logic [5:0] a, input logic [7:0] d);
    cpu_addr = a; cpu_wrdata = d; cpu_write = 1'b1;
    step();
    cpu_write = 1'b0;
  endtask

  task automatic env_wr(input logic [3:0] a, input logic [7:0] d);
    env_addr = a; env_wrdata = d; env_write = 1'b1;
    step();
    env_write = 1'b0;
  endtask

  task automatic tick_wait();
    int n;
    n = 0;
    next_sample = 1'b1;
    step();
    next_sample = 1'b0;
    while (busy && n < 100) begin
      n++;
      step();
    end
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL scan_timeout: busy=%b after %0d cycles, required 0", busy, n);
    end
  endtask

  task automatic test_reset();
    n_checks++;
    if ({psg_attr_addr, psg_attr_wrdata, psg_attr_write, busy, tick_overrun} !== 17'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h required 0",
               {psg_attr_addr, psg_attr_wrdata, psg_attr_write, busy, tick_overrun});
    end
    n_checks++;
    if ({d_addr, d_data, d_write, d_busy, d_ovr} !== 17'd0) begin
      n_fail++;
      $display("FAIL reset_div_outputs: got %h required 0", {d_addr, d_data, d_write, d_busy, d_ovr});
    end
    for (int i = 0; i < 16; i++) env_wr(4'(i), 8'h3F);
    next_sample = 1'b1;
    for (int i = 0; i < 8; i++) step();
    #2 rst = 1'b1;
    #1;
    wlog.delete();
    n_checks++;
    if ({psg_attr_addr, psg_attr_wrdata, psg_attr_write, busy, tick_overrun} !== 17'd0) begin
      n_fail++;
      $display("FAIL reset_midscan: got %h required 0",
               {psg_attr_addr, psg_attr_wrdata, psg_attr_write, busy, tick_overrun});
    end
    next_sample = 1'b0;
    step(); step();
    rst = 1'b0;
    for (int i = 0; i < 20; i++) step();
    tick_wait();
    n_checks++;
    if (wlog.size() != 0) begin
      n_fail++;
      $display("FAIL reset_no_writes: got %0d writes required 0", wlog.size());
    end
  endtask

  task automatic test_passthrough();
    int n;
    do_reset();
    cpu_wr(6'h05, 8'h3C);
    n_checks++;
    if ({psg_attr_addr, psg_attr_wrdata, psg_attr_write} !== {6'h05, 8'h3C, 1'b1}) begin
      n_fail++;
      $display("FAIL pass_out: got %h/%h/%b required 05/3c/1", psg_attr_addr, psg_attr_wrdata, psg_attr_write);
    end
    step();
    n_checks++;
    if (psg_attr_write !== 1'b0) begin
      n_fail++;
      $display("FAIL pass_one_cycle: write=%b required 0", psg_attr_write);
    end
    next_sample = 1'b1;
    step();
    next_sample = 1'b0;
    n = 0;
    while (busy && n < 100) begin
      n++;
      step();
    end
    n_checks++;
    if (n != 16) begin
      n_fail++;
      $display("FAIL idle_scan_len: got %0d cycles required 16", n);
    end
    n_checks++;
    if (wlog.size() != 1) begin
      n_fail++;
      $display("FAIL idle_scan_writes: got %0d writes required 1", wlog.size());
    end
  endtask

  task automatic test_ramp_up();
    logic [13:0] exp_w [6];
    exp_w = '{{6'h0E, 8'hCA}, {6'h0E, 8'hCC}, {6'h0E, 8'hCE}, {6'h0E, 8'hD0}, {6'h0E, 8'hD2}, {6'h0E, 8'hD4}};
    do_reset();
    cpu_wr(6'h0E, 8'hCA);
    env_wr(4'd3, 8'h54);
    for (int i = 0; i < 8; i++) tick_wait();
    n_checks++;
    if (wlog.size() != 6) begin
      n_fail++;
      $display("FAIL ramp_count: got %0d writes required 6", wlog.size());
    end
    for (int i = 0; i < 6; i++) begin
      if (i < wlog.size()) begin
        n_checks++;
        if (wlog[i] !== exp_w[i]) begin
          n_fail++;
          $display("FAIL ramp_w%0d: got %h required %h", i, wlog[i], exp_w[i]);
        end
      end
    end
  endtask

  task automatic test_clamp_down();
    logic [13:0] exp_w [5];
    exp_w = '{{6'h02, 8'h12}, {6'h02, 8'h15}, {6'h02, 8'h0D}, {6'h02, 8'h05}, {6'h02, 8'h00}};
    do_reset();
    cpu_wr(6'h02, 8'h0A);
    env_wr(4'd0, 8'hD5);
    wlog.delete();
    for (int i = 0; i < 3; i++) tick_wait();
    n_checks++;
    if (wlog.size() != 2) begin
      n_fail++;
      $display("FAIL clamp_up_count: got %0d writes required 2", wlog.size());
    end
    env_wr(4'd0, 8'hC0);
    for (int i = 0; i < 5; i++) tick_wait();
    n_checks++;
    if (wlog.size() != 5) begin
      n_fail++;
      $display("FAIL clamp_down_count: got %0d writes required 5", wlog.size());
    end
    for (int i = 0; i < 5; i++) begin
      if (i < wlog.size()) begin
        n_checks++;
        if (wlog[i] !== exp_w[i]) begin
          n_fail++;
          $display("FAIL clamp_w%0d: got %h required %h", i, wlog[i], exp_w[i]);
        end
      end
    end
  endtask

  task automatic collide(input logic [5:0] ca, input logic [7:0] cd, input logic [7:0] eng_d);
    next_sample = 1'b1;
    step();
    next_sample = 1'b0;
    step(); step(); step(); step();
    cpu_addr = ca; cpu_wrdata = cd; cpu_write = 1'b1;
    step();
    cpu_write = 1'b0;
    n_checks++;
    if ({psg_attr_addr, psg_attr_wrdata, psg_attr_write} !== {ca, cd, 1'b1}) begin
      n_fail++;
      $display("FAIL coll_cpu_first: got %h/%h/%b required %h/%h/1",
               psg_attr_addr, psg_attr_wrdata, psg_attr_write, ca, cd);
    end
    step();
    n_checks++;
    if (psg_attr_write !== 1'b0) begin
      n_fail++;
      $display("FAIL coll_rescan_gap: write=%b required 0", psg_attr_write);
    end
    step();
    n_checks++;
    if ({psg_attr_addr, psg_attr_wrdata, psg_attr_write} !== {6'h0E, eng_d, 1'b1}) begin
      n_fail++;
      $display("FAIL coll_engine: got %h/%h/%b required 0e/%h/1",
               psg_attr_addr, psg_attr_wrdata, psg_attr_write, eng_d);
    end
    while (busy) step();
  endtask

  task automatic test_collision();
    do_reset();
    cpu_wr(6'h0E, 8'hCA);
    env_wr(4'd3, 8'h54);
    collide(6'h1C, 8'h55, 8'hCC);
    collide(6'h0E, 8'h41, 8'h43);
  endtask

  task automatic test_overrun();
    int n;
    int ovr;
    do_reset();
    for (int i = 0; i < 16; i++) env_wr(4'(i), 8'h3F);
    wlog.delete();
    next_sample = 1'b1;
    step();
    n = 0;
    ovr = 0;
    while (busy && n < 100) begin
      n++;
      step();
      if (tick_overrun) ovr++;
    end
    n_checks++;
    if (n != 32) begin
      n_fail++;
      $display("FAIL ovr_scan_len: got %0d cycles required 32", n);
    end
    n_checks++;
    if (ovr != 32) begin
      n_fail++;
      $display("FAIL ovr_pulses: got %0d required 32", ovr);
    end
    step();
    n_checks++;
    if ({busy, tick_overrun} !== 2'b10) begin
      n_fail++;
      $display("FAIL ovr_restart: busy/ovr=%b required 10", {busy, tick_overrun});
    end
    n_checks++;
    if (wlog.size() != 16) begin
      n_fail++;
      $display("FAIL ovr_writes: got %0d required 16", wlog.size());
    end
    for (int i = 0; i < 16; i++) begin
      if (i < wlog.size()) begin
        n_checks++;
        if (wlog[i] !== {4'(i), 2'b10, 8'h01}) begin
          n_fail++;
          $display("FAIL ovr_w%0d: got %h required %h", i, wlog[i], {4'(i), 2'b10, 8'h01});
        end
      end
    end
    next_sample = 1'b0;
    n = 0;
    while (busy && n < 100) begin
      n++;
      step();
    end
  endtask

  task automatic test_tick_div();
    do_reset();
    for (int p = 1; p <= 3; p++) begin
      ns3 = 1'b1;
      step();
      ns3 = 1'b0;
      n_checks++;
      if (d_busy !== (p == 3)) begin
        n_fail++;
        $display("FAIL div_pulse%0d: busy=%b required %b", p, d_busy, (p == 3));
      end
      step();
    end
  endtask

  initial begin
    do_reset();
    test_reset();
    test_passthrough();
    test_ramp_up();
    test_clamp_down();
    test_collision();
    test_overrun();
    test_tick_div();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
